// File: rtl/multi_cycle_adder.sv
// multi_cycle_adder: sequential add/subtract of two WIDTH-bit operands, CHUNK bits per clock,
// LSB chunk first, with the running carry held in a register between chunks.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid_i   operands and mode valid          in_ready_o   block can accept (IDLE only)
//   a_i, b_i     operands                          cin_i        carry-in (ignored when sub_i)
//   sub_i        0: a + b + cin, 1: a - b (a + ~b + 1)
//   out_valid_o  result valid (DONE only)          out_ready_i  consumer accepts result
//   sum_o        result                            carry_o      final carry (1 = no borrow on sub)
//   overflow_o   two's-complement signed overflow
module multi_cycle_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int unsigned NumChunks = WIDTH / CHUNK;
  localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumChunks - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             carry_into_msb;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    base      = 32'(cnt_q) * CHUNK;
    a_chunk   = op_a_q[base +: CHUNK];
    b_chunk   = op_b_q[base +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    // Sum bit = a ^ b ^ cin, so the carry into the chunk MSB is recovered without a second adder.
    carry_into_msb = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          op_a_d  = a_i;
          op_b_d  = b_i ^ {WIDTH{sub_i}};
          carry_d = sub_i ? 1'b1 : cin_i;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        acc_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d              = chunk_sum[CHUNK];
        if (cnt_q == LastCnt) begin
          // Counter parks at 0 so the part-select never points past the operands.
          cnt_d   = '0;
          sum_d   = acc_d;
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = carry_into_msb ^ chunk_sum[CHUNK];
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign sum_o       = sum_q;
  assign carry_o     = cout_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Bench for multi_cycle_adder: three instances (CHUNK = 4, 16, 1) at WIDTH = 16. Expected results
// come from signed/unsigned integer arithmetic and are queued on accept; one monitor pops them.
module tb_multi_cycle_adder;

  localparam int unsigned W = 16;

  typedef logic [W+1:0] exp_t;  // {overflow, carry, sum}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_w       [3];
  logic         in_valid_w  [3];
  logic         in_ready_w  [3];
  logic [W-1:0] a_w         [3];
  logic [W-1:0] b_w         [3];
  logic         cin_w       [3];
  logic         sub_w       [3];
  logic         out_valid_w [3];
  logic         out_ready_w [3];
  logic [W-1:0] sum_w       [3];
  logic         carry_w     [3];
  logic         ovf_w       [3];

  exp_t exp_q [3][$];

  int   total = 0;
  int   bad   = 0;
  logic rand_rdy = 1'b0;
  logic hold_rdy = 1'b1;

  function automatic int unsigned chunk_of(input int idx);
    case (idx)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned C = chunk_of(g);
    multi_cycle_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk        (clk),
      .rst_n      (rst_w[g]),
      .in_valid_i (in_valid_w[g]),
      .in_ready_o (in_ready_w[g]),
      .a_i        (a_w[g]),
      .b_i        (b_w[g]),
      .cin_i      (cin_w[g]),
      .sub_i      (sub_w[g]),
      .out_valid_o(out_valid_w[g]),
      .out_ready_i(out_ready_w[g]),
      .sum_o      (sum_w[g]),
      .carry_o    (carry_w[g]),
      .overflow_o (ovf_w[g])
    );
  end

  // Reference: plain integer arithmetic on the operation's definition.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    int          sa = int'($signed(a));
    int          sb = int'($signed(b));
    int          r;
    logic [W:0]  u;
    logic        ov;
    if (sub) begin
      u = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      r = sa - sb;
    end else begin
      u = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      r = sa + sb + int'(cin);
    end
    ov = (r > 32767) || (r < -32768);
    return {ov, u[W], u[W-1:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) out_ready_w[i] = rand_rdy ? 1'($urandom_range(0, 1)) : hold_rdy;
  end

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_w[i] === 1'b1 && out_valid_w[i] === 1'b1 && out_ready_w[i] === 1'b1) begin
        if (exp_q[i].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output inst%0d: got sum=%h, expected no output", i, sum_w[i]);
        end else begin
          exp_t e;
          e = exp_q[i].pop_front();
          check($sformatf("result inst%0d", i), 32'({ovf_w[i], carry_w[i], sum_w[i]}), 32'(e));
        end
      end
    end
  end

  task automatic issue(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    int n = 0;
    a_w[idx] = a; b_w[idx] = b; cin_w[idx] = cin; sub_w[idx] = sub;
    in_valid_w[idx] = 1'b1;
    @(negedge clk);
    while (in_ready_w[idx] !== 1'b1) begin
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL accept_timeout inst%0d: got in_ready=%b, expected 1", idx, in_ready_w[idx]);
        in_valid_w[idx] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    exp_q[idx].push_back(model(a, b, cin, sub));
    @(posedge clk);
    #1;
    in_valid_w[idx] = 1'b0;
    // Scramble operands after accept; they must have no effect.
    a_w[idx] = W'($urandom); b_w[idx] = W'($urandom);
    cin_w[idx] = 1'($urandom); sub_w[idx] = 1'($urandom);
  endtask

  // Called right after the accept edge; counts edges until out_valid is seen.
  task automatic wait_out(input int idx, input bit chk_lat);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (out_valid_w[idx] !== 1'b1 && n < 200);
    if (chk_lat) check($sformatf("latency inst%0d", idx), 32'(n), 32'(W / chunk_of(idx)));
    else if (out_valid_w[idx] !== 1'b1) check($sformatf("out_valid_timeout inst%0d", idx),
                                             32'(out_valid_w[idx]), 32'(1));
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                     input logic sub);
    int n = 0;
    issue(0, a, b, cin, sub);
    wait_out(0, 1'b1);
    while (out_valid_w[0] === 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic rand_ops(input int idx, input int count);
    for (int k = 0; k < count; k++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 7) == 0) a = W'(16'h7FFF + $urandom_range(0, 1));
      issue(idx, a, b, 1'($urandom), 1'($urandom));
      if (k == 0) wait_out(idx, 1'b1);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      rst_w[i] = 1'b0; in_valid_w[i] = 1'b0;
      a_w[i] = '0; b_w[i] = '0; cin_w[i] = 1'b0; sub_w[i] = 1'b0;
    end
    #1;
    check("reset in_ready", 32'(in_ready_w[0]), 32'(1));
    check("reset out_valid", 32'(out_valid_w[0]), 32'(0));
    check("reset sum/carry/ovf", 32'({ovf_w[0], carry_w[0], sum_w[0]}), 32'(0));
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst_w[i] = 1'b1;
    @(posedge clk);
    #1;

    // Directed arithmetic on the CHUNK = 4 instance.
    run(16'h1234, 16'h1111, 1'b0, 1'b0);
    run(16'h00FF, 16'h0000, 1'b1, 1'b0);
    run(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run(16'h0005, 16'h0007, 1'b1, 1'b1);
    run(16'h8000, 16'h0001, 1'b0, 1'b1);

    // Backpressure with inputs toggling in DONE.
    @(negedge clk);
    hold_rdy = 1'b0;
    @(posedge clk);
    #1;
    issue(0, 16'h0F0F, 16'h0101, 1'b0, 1'b0);
    wait_out(0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      in_valid_w[0] = 1'b1;
      a_w[0] = 16'hAAAA;
      @(negedge clk);
      check($sformatf("bp out_valid %0d", k), 32'(out_valid_w[0]), 32'(1));
      check($sformatf("bp in_ready %0d", k), 32'(in_ready_w[0]), 32'(0));
      check($sformatf("bp sum %0d", k), 32'(sum_w[0]), 32'(16'h1010));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    in_valid_w[0] = 1'b0;
    hold_rdy = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("bp release in_ready", 32'(in_ready_w[0]), 32'(1));
    check("bp release out_valid", 32'(out_valid_w[0]), 32'(0));
    repeat (10) @(posedge clk);
    #1;

    // Reset during the second BUSY cycle.
    issue(0, 16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_w[0] = 1'b0;
    exp_q[0].delete();
    #1;
    check("midreset out_valid", 32'(out_valid_w[0]), 32'(0));
    check("midreset in_ready", 32'(in_ready_w[0]), 32'(1));
    check("midreset sum/carry/ovf", 32'({ovf_w[0], carry_w[0], sum_w[0]}), 32'(0));
    repeat (2) @(negedge clk);
    rst_w[0] = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    run(16'h0001, 16'h0002, 1'b0, 1'b0);

    // Random phase on all three configurations with random backpressure.
    @(negedge clk);
    rand_rdy = 1'b1;
    @(posedge clk);
    #1;
    fork
      rand_ops(0, 200);
      rand_ops(1, 1000);
      rand_ops(2, 1000);
    join

    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) check($sformatf("drain inst%0d", i), 32'(exp_q[i].size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
